// File: rtl/max7219_pkg.sv
// Shared definitions for the MAX7219 command sequencer: register addresses,
// FSM encoding, sequence lengths and the SPI word formatter.
package max7219_pkg;

   localparam logic [3:0] ADDR_NOOP      = 4'h0;
   localparam logic [3:0] ADDR_DIGIT0    = 4'h1;
   localparam logic [3:0] ADDR_DECODE    = 4'h9;
   localparam logic [3:0] ADDR_INTENSITY = 4'hA;
   localparam logic [3:0] ADDR_SCAN      = 4'hB;
   localparam logic [3:0] ADDR_SHUTDOWN  = 4'hC;
   localparam logic [3:0] ADDR_TEST      = 4'hF;

   localparam int INIT_LEN  = 6;
   localparam int DIGIT_CNT = 8;

   typedef enum logic [2:0] {
      ST_INIT,
      ST_IDLE,
      ST_LATCH,
      ST_ISSUE,
      ST_WAIT
   } state_t;

   function automatic logic [15:0] make_word(input logic [3:0] addr, input logic [7:0] data);
      return {4'h0, addr, data};
   endfunction

endpackage

// File: rtl/max7219_refresh_tick.sv
// Free-running divider: one-cycle tick every REFRESH_DIV enabled clock cycles.
module max7219_refresh_tick #(
   parameter int REFRESH_DIV = 500_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   output logic tick
);

   localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(REFRESH_DIV - 1);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt  <= '0;
         tick <= 1'b0;
      end else begin
         tick <= 1'b0;
         if (en) begin
            if (cnt == LAST) begin
               cnt  <= '0;
               tick <= 1'b1;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/max7219_ctrl.sv
// MAX7219 command sequencer: sends the init words once, then refreshes the
// eight digit registers from a snapshot of the BCD bus on tick or request.
module max7219_ctrl
   import max7219_pkg::*;
#(
   parameter logic [7:0] DECODE_MODE = 8'hFF,
   parameter logic [3:0] INTENSITY   = 4'h8,
   parameter logic [2:0] SCAN_LIMIT  = 3'd7,
   parameter int         REFRESH_DIV = 500_000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] digits_in,
   input  logic [7:0]  dp_in,
   input  logic        update,
   output logic        spi_start,
   output logic [15:0] spi_data,
   input  logic        spi_busy,
   input  logic        spi_done,
   output logic        init_done,
   output logic        frame_done
);

   state_t      state;
   logic [2:0]  index;
   logic        init_phase;
   logic        pending;
   logic [31:0] bcd_snap;
   logic [7:0]  dp_snap;
   logic        tick;
   logic        last_word;
   logic [15:0] word;

   max7219_refresh_tick #(
      .REFRESH_DIV(REFRESH_DIV)
   ) u_tick (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (init_done),
      .tick (tick)
   );

   assign last_word = init_phase ? (index == 3'(INIT_LEN - 1)) : (index == 3'(DIGIT_CNT - 1));

   always_comb begin
      word = '0;
      if (init_phase) begin
         case (index)
            3'd0:    word = make_word(ADDR_SHUTDOWN, 8'h00);
            3'd1:    word = make_word(ADDR_TEST, 8'h00);
            3'd2:    word = make_word(ADDR_DECODE, DECODE_MODE);
            3'd3:    word = make_word(ADDR_INTENSITY, {4'h0, INTENSITY});
            3'd4:    word = make_word(ADDR_SCAN, {5'b0_0000, SCAN_LIMIT});
            3'd5:    word = make_word(ADDR_SHUTDOWN, 8'h01);
            default: word = make_word(ADDR_NOOP, 8'h00);
         endcase
      end else begin
         // Nibbles above 9 go through untouched; the chip maps them to Code-B symbols.
         word = make_word(ADDR_DIGIT0 + {1'b0, index},
                          {dp_snap[index], 3'b000, bcd_snap[{index, 2'b00} +: 4]});
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= ST_INIT;
         index      <= '0;
         init_phase <= 1'b1;
         pending    <= 1'b0;
         spi_start  <= 1'b0;
         spi_data   <= '0;
         init_done  <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         spi_start  <= 1'b0;
         frame_done <= 1'b0;
         case (state)
            ST_INIT: begin
               index      <= '0;
               init_phase <= 1'b1;
               state      <= ST_ISSUE;
            end
            ST_IDLE: begin
               if (pending) begin
                  pending <= 1'b0;
                  state   <= ST_LATCH;
               end
            end
            ST_LATCH: begin
               bcd_snap   <= digits_in;
               dp_snap    <= dp_in;
               index      <= '0;
               init_phase <= 1'b0;
               state      <= ST_ISSUE;
            end
            ST_ISSUE: begin
               if (!spi_busy) begin
                  spi_data  <= word;
                  spi_start <= 1'b1;
                  state     <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (spi_done) begin
                  if (last_word) begin
                     state <= ST_IDLE;
                     if (init_phase) init_done  <= 1'b1;
                     else            frame_done <= 1'b1;
                  end else begin
                     index <= index + 3'd1;
                     state <= ST_ISSUE;
                  end
               end
            end
            default: state <= ST_INIT;
         endcase
         // A request landing on the LATCH-entry cycle must survive the clear above.
         if (update || tick) pending <= 1'b1;
      end
   end

endmodule

// File: tb/tb_max7219_ctrl.sv
// Scoreboard bench for max7219_ctrl: a slow-refresh instance for directed frames
// and a REFRESH_DIV=100 instance for periodic refresh behaviour.
module tb_max7219_ctrl;

   localparam int SLOW_DIV = 60000;
   localparam int FAST_DIV = 100;
   localparam int XFER     = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic        rst_n      [2];
   logic [31:0] digits     [2];
   logic [7:0]  dp         [2];
   logic        update     [2];
   logic        start      [2];
   logic [15:0] sdata      [2];
   logic        busy       [2];
   logic        done_m     [2];
   logic        done       [2];
   logic        init_done  [2];
   logic        frame_done [2];
   logic        stray;

   assign done[0] = done_m[0] | stray;
   assign done[1] = done_m[1];

   max7219_ctrl #(.REFRESH_DIV(SLOW_DIV)) dut_slow (
      .clk(clk), .rst_n(rst_n[0]), .digits_in(digits[0]), .dp_in(dp[0]),
      .update(update[0]), .spi_start(start[0]), .spi_data(sdata[0]),
      .spi_busy(busy[0]), .spi_done(done[0]), .init_done(init_done[0]),
      .frame_done(frame_done[0])
   );

   max7219_ctrl #(.REFRESH_DIV(FAST_DIV)) dut_fast (
      .clk(clk), .rst_n(rst_n[1]), .digits_in(digits[1]), .dp_in(dp[1]),
      .update(update[1]), .spi_start(start[1]), .spi_data(sdata[1]),
      .spi_busy(busy[1]), .spi_done(done[1]), .init_done(init_done[1]),
      .frame_done(frame_done[1])
   );

   int tests  = 0;
   int errors = 0;

   logic [15:0] q0[$];
   logic [15:0] q1[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic timeout(input string name);
      tests++;
      errors++;
      $display("FAIL %s: timed out at cycle %0d", name, cyc);
   endtask

   function automatic int qsize(input int d);
      return (d == 0) ? q0.size() : q1.size();
   endfunction

   task automatic push_word(input int d, input logic [15:0] w);
      if (d == 0) q0.push_back(w);
      else        q1.push_back(w);
   endtask

   task automatic push_init(input int d);
      push_word(d, 16'h0C00); push_word(d, 16'h0F00); push_word(d, 16'h09FF);
      push_word(d, 16'h0A08); push_word(d, 16'h0B07); push_word(d, 16'h0C01);
   endtask

   task automatic push_frame(input int d, input logic [31:0] dig, input logic [7:0] dpv, input int nwords);
      for (int i = 0; i < nwords; i++)
         push_word(d, {4'h0, 4'(i + 1), dpv[i], 3'b000, dig[i*4 +: 4]});
   endtask

   // SPI master model: busy for XFER+1 cycles after start, then a done pulse;
   // busy may be stretched by hold[d] cycles after done.
   int hold[2] = '{0, 0};
   int xc[2]   = '{0, 0};
   int hc[2]   = '{0, 0};
   bit act[2]  = '{0, 0};

   initial begin
      busy[0] = 1'b0; busy[1] = 1'b0; done_m[0] = 1'b0; done_m[1] = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         for (int d = 0; d < 2; d++) begin
            done_m[d] = 1'b0;
            if (!rst_n[d]) begin
               act[d] = 0; hc[d] = 0; busy[d] = 1'b0;
            end else begin
               if (act[d]) begin
                  if (xc[d] == 0) begin
                     done_m[d] = 1'b1;
                     act[d] = 0;
                     if (hold[d] > 0) begin hc[d] = hold[d]; busy[d] = 1'b1; end
                     else busy[d] = 1'b0;
                  end else xc[d]--;
               end else if (hc[d] > 0) begin
                  hc[d]--;
                  if (hc[d] == 0) busy[d] = 1'b0;
               end
               if (start[d]) begin act[d] = 1; xc[d] = XFER; busy[d] = 1'b1; end
            end
         end
      end
   end

   // Monitor / scoreboard
   bit          outst[2]     = '{0, 0};
   logic [15:0] out_data[2]  = '{16'h0, 16'h0};
   logic        prev_busy[2] = '{1'b0, 1'b0};
   logic        prev_init[2] = '{1'b0, 1'b0};
   int          last_done[2] = '{0, 0};
   logic [3:0]  last_addr[2] = '{4'h0, 4'h0};
   int          done_cnt[2]  = '{0, 0};
   int          starts[2]    = '{0, 0};
   int          frames[2]    = '{0, 0};
   int          last_fs[2]   = '{-1, -1};

   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (!rst_n[d]) begin
            outst[d] = 0; done_cnt[d] = 0; prev_init[d] = 1'b0;
            prev_busy[d] = 1'b0; last_fs[d] = -1;
         end else begin
            if (start[d] === 1'b1) begin
               logic [15:0] exp;
               bit ok;
               starts[d]++;
               ok = !outst[d] && !prev_busy[d] && (done_cnt[d] == 0 || cyc - last_done[d] >= 2);
               check($sformatf("start_legal dut%0d", d), 32'(ok), 32'd1);
               if (qsize(d) == 0) begin
                  tests++;
                  errors++;
                  $display("FAIL unexpected_start dut%0d: got word %h, required no start (cycle %0d)",
                           d, sdata[d], cyc);
               end else begin
                  exp = (d == 0) ? q0.pop_front() : q1.pop_front();
                  check($sformatf("word dut%0d", d), 32'(sdata[d]), 32'(exp));
               end
               outst[d] = 1; out_data[d] = sdata[d];
               if (sdata[d][11:8] == 4'h1) begin
                  if (d == 1 && last_fs[d] >= 0)
                     check("frame_period", 32'(cyc - last_fs[d]), 32'd100);
                  last_fs[d] = cyc;
               end
            end
            if (done[d] === 1'b1 && outst[d]) begin
               check($sformatf("data_stable dut%0d", d), 32'(sdata[d]), 32'(out_data[d]));
               outst[d] = 0; done_cnt[d]++; last_done[d] = cyc; last_addr[d] = out_data[d][11:8];
            end
            if (frame_done[d] === 1'b1) begin
               frames[d]++;
               check($sformatf("frame_done_timing dut%0d", d),
                     {30'd0, last_addr[d] == 4'h8, cyc - last_done[d] == 1}, 32'd3);
            end
            if (init_done[d] === 1'b1 && !prev_init[d])
               check($sformatf("init_done_timing dut%0d", d),
                     {30'd0, done_cnt[d] == 6, cyc - last_done[d] == 1}, 32'd3);
            prev_init[d] = init_done[d];
            prev_busy[d] = busy[d];
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_update(input int d);
      update[d] = 1'b1;
      idle(1);
      update[d] = 1'b0;
   endtask

   task automatic drain(input int d, input int budget);
      int k = 0;
      while (qsize(d) != 0 || outst[d]) begin
         idle(1);
         k++;
         if (k > budget) begin
            timeout($sformatf("drain dut%0d (%0d words left)", d, qsize(d)));
            if (d == 0) q0.delete(); else q1.delete();
            return;
         end
      end
      idle(3);
   endtask

   task automatic wait_starts(input int d, input int n, input int budget);
      int k = 0;
      while (starts[d] < n) begin
         idle(1);
         k++;
         if (k > budget) begin
            timeout($sformatf("wait_starts dut%0d", d));
            return;
         end
      end
   endtask

   task automatic wait_cyc(input int n);
      while (cyc < n) idle(1);
   endtask

   task automatic check_reset_outputs(input int d);
      check($sformatf("rst spi_start dut%0d", d), 32'(start[d]), 32'd0);
      check($sformatf("rst spi_data dut%0d", d), 32'(sdata[d]), 32'd0);
      check($sformatf("rst init_done dut%0d", d), 32'(init_done[d]), 32'd0);
      check($sformatf("rst frame_done dut%0d", d), 32'(frame_done[d]), 32'd0);
   endtask

   initial begin
      int base;
      int s3;
      stray = 1'b0;
      for (int d = 0; d < 2; d++) begin
         rst_n[d] = 1'b0; update[d] = 1'b0; digits[d] = '0; dp[d] = '0;
      end
      idle(3);
      check_reset_outputs(0);

      // 1: init sequence
      push_init(0);
      rst_n[0] = 1'b1;
      drain(0, 300);
      check("init_done high", 32'(init_done[0]), 32'd1);

      // 2: one requested frame
      digits[0] = 32'h7654_3210;
      dp[0]     = 8'h01;
      push_word(0, 16'h0180); push_word(0, 16'h0201); push_word(0, 16'h0302); push_word(0, 16'h0403);
      push_word(0, 16'h0504); push_word(0, 16'h0605); push_word(0, 16'h0706); push_word(0, 16'h0807);
      pulse_update(0);
      drain(0, 300);
      check("frames after test2", 32'(frames[0]), 32'd1);

      // stray done while idle must not start anything
      stray = 1'b1;
      idle(1);
      stray = 1'b0;
      idle(20);
      check("starts after stray done", 32'(starts[0]), 32'd14);

      // 3: SPI master stays busy 40 cycles after each done; nibbles above 9
      hold[0]   = 40;
      digits[0] = 32'h89AB_CDEF;
      dp[0]     = 8'h80;
      push_frame(0, digits[0], dp[0], 8);
      pulse_update(0);
      drain(0, 1000);
      hold[0] = 0;
      check("frames after test3", 32'(frames[0]), 32'd2);

      // 4: three updates mid-frame merge into exactly one extra frame
      base      = starts[0];
      digits[0] = 32'h0246_8ACE;
      dp[0]     = 8'h3C;
      push_frame(0, digits[0], dp[0], 8);
      pulse_update(0);
      wait_starts(0, base + 3, 200);
      pulse_update(0);
      idle(5);
      pulse_update(0);
      idle(7);
      pulse_update(0);
      digits[0] = 32'h1357_9BDF;
      dp[0]     = 8'hC3;
      push_frame(0, digits[0], dp[0], 8);
      drain(0, 400);
      idle(100);
      check("starts after test4", 32'(starts[0]), 32'(base + 16));
      check("frames after test4", 32'(frames[0]), 32'd4);

      // 6: reset during digit word 4, update held across the restarted init
      base      = starts[0];
      digits[0] = 32'h9876_5432;
      dp[0]     = 8'hFF;
      push_frame(0, digits[0], dp[0], 4);
      pulse_update(0);
      wait_starts(0, base + 4, 200);
      idle(1);
      rst_n[0] = 1'b0;
      idle(1);
      check_reset_outputs(0);
      @(negedge clk);
      rst_n[0] = 1'b1;
      idle(1);
      push_init(0);
      wait_starts(0, base + 6, 200);
      pulse_update(0);
      push_frame(0, digits[0], dp[0], 8);
      drain(0, 400);
      check("init_done after restart", 32'(init_done[0]), 32'd1);
      check("frames after test6", 32'(frames[0]), 32'd5);

      // 5: periodic refresh with REFRESH_DIV=100; snapshot isolates a frame from bus changes
      check_reset_outputs(1);
      digits[1] = 32'h1234_5678;
      dp[1]     = 8'h0F;
      push_init(1);
      push_frame(1, digits[1], dp[1], 8);
      push_frame(1, digits[1], dp[1], 8);
      rst_n[1] = 1'b1;
      wait_starts(1, 18, 600);
      digits[1] = 32'hFEDC_BA98;
      dp[1]     = 8'hA5;
      push_frame(1, digits[1], dp[1], 8);
      push_frame(1, digits[1], dp[1], 8);
      wait_starts(1, 23, 300);
      s3 = last_fs[1];
      // update coincides with the next refresh tick: one frame, still on the 100-cycle grid
      wait_cyc(s3 + 96);
      pulse_update(1);
      wait_cyc(s3 + 190);
      check("fast starts", 32'(starts[1]), 32'd38);
      check("fast frames", 32'(frames[1]), 32'd4);
      check("fast queue empty", 32'(qsize(1)), 32'd0);
      rst_n[1] = 1'b0;
      idle(2);
      check_reset_outputs(1);

      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

endmodule
